// File: rtl/sprite_msg_pkg.sv
// sprite_msg_pkg: shared definitions for the sprite message format used by the
// HPS command dispatcher and every display module (cloud, Mario, blocks, ...).
//
// Message layout (32 bits):
//   [31:26] component  [25:21] child  [20:17] info  [16:14] data_type
//   [13]    buffer     [12:0]  message_data
//
// Contents: field bit positions, info codes, the idle bus word, the dispatcher
// FSM state type and small helpers for building / editing messages.
package sprite_msg_pkg;

   localparam int COMPONENT_MSB = 31;
   localparam int COMPONENT_LSB = 26;
   localparam int CHILD_MSB     = 25;
   localparam int CHILD_LSB     = 21;
   localparam int INFO_MSB      = 20;
   localparam int INFO_LSB      = 17;
   localparam int DTYPE_MSB     = 16;
   localparam int DTYPE_LSB     = 14;
   localparam int BUFFER_BIT    = 13;
   localparam int DATA_MSB      = 12;
   localparam int DATA_LSB      = 0;

   localparam logic [3:0]  INFO_UPDATE = 4'h1;
   localparam logic [3:0]  INFO_FLUSH  = 4'hF;

   // info = 0 on the broadcast bus is ignored by every display module.
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      DRAIN = 2'd2
   } disp_state_e;

   // Extract the info field of a message.
   function automatic logic [3:0] msg_info(input logic [31:0] word);
      return word[INFO_MSB:INFO_LSB];
   endfunction

   // Build the double-buffer switch word that activates buffer 'buf_sel'.
   function automatic logic [31:0] make_flush_word(input logic buf_sel);
      logic [31:0] word;
      word = NOP_WORD;
      word[COMPONENT_MSB:COMPONENT_LSB] = 6'h00;
      word[INFO_MSB:INFO_LSB]           = INFO_FLUSH;
      word[BUFFER_BIT]                  = buf_sel;
      return word;
   endfunction

   // Replace the buffer bit of a message, everything else passes unchanged.
   function automatic logic [31:0] with_buffer(input logic [31:0] word, input logic buf_sel);
      logic [31:0] result;
      result             = word;
      result[BUFFER_BIT] = buf_sel;
      return result;
   endfunction

endpackage

// File: rtl/sprite_cmd_dispatcher_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//
// Ports:
//   clk, reset (async, active-low)
//   push / push_data : enqueue when not full (ignored when full)
//   pop  / pop_data  : dequeue when not empty; pop_data shows the head entry
//   full, empty      : status derived from the occupancy counter
//   level            : occupancy 0..DEPTH (one bit wider than the pointers)
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int             AW        = $clog2(DEPTH);
   localparam logic [AW-1:0]  PTR_ONE   = AW'(1);
   localparam logic [AW:0]    CNT_ONE   = (AW+1)'(1);
   localparam logic [AW:0]    CNT_ZERO  = (AW+1)'(0);
   localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             do_push_s;
   logic             do_pop_s;

   // Qualify requests with status; pointers wrap naturally at DEPTH.
   always_comb begin
      full      = (count_r == DEPTH_CNT);
      empty     = (count_r == CNT_ZERO);
      do_push_s = push && !full;
      do_pop_s  = pop && !empty;
      pop_data  = mem_r[rd_ptr_r];
      level     = count_r;
   end

   // Storage array; contents need no reset since pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers and occupancy counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= CNT_ZERO;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/sprite_cmd_dispatcher.sv
// sprite_cmd_dispatcher: frame-synchronous command queue between the HPS
// Avalon-MM write port and the sprite display modules. Software messages are
// buffered and only broadcast during vertical blanking, each burst preceded by
// a double-buffer flush/switch word.
//
// Ports:
//   clk, reset (async, active-low)
//   chipselect, write, writedata[31:0] : Avalon-MM slave write port
//   vcount[9:0]                        : current VGA line
//   cmd_out[31:0]                      : registered broadcast word (NOP when idle)
//   front_buffer                       : buffer activated by the latest flush word
//   fifo_level                         : queued entries, 0..FIFO_DEPTH
//   overflow                           : sticky, a write was dropped (FIFO full)
//   rejected                           : sticky, a software word with info = F was dropped
module sprite_cmd_dispatcher
   import sprite_msg_pkg::*;
#(
   parameter int         FIFO_DEPTH  = 64,
   parameter logic [9:0] VBLANK_LINE = 10'd480
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          chipselect,
   input  logic                          write,
   input  logic [31:0]                   writedata,
   input  logic [9:0]                    vcount,
   output logic [31:0]                   cmd_out,
   output logic                          front_buffer,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic                          rejected
);

   disp_state_e state_r;
   disp_state_e state_next_s;

   logic        in_blank_r;
   logic        in_blank_prev_r;
   logic        blank_rise_s;
   logic        sw_write_s;
   logic        info_flush_s;
   logic        push_s;
   logic        pop_s;
   logic        toggle_s;
   logic        fifo_full_s;
   logic        fifo_empty_s;
   logic [31:0] fifo_data_s;
   logic [31:0] cmd_next_s;
   logic [31:0] cmd_out_r;
   logic        front_buffer_r;
   logic        overflow_r;
   logic        rejected_r;

   // Software write decode; flush words may only originate from this block.
   always_comb begin
      sw_write_s   = chipselect && write;
      info_flush_s = (msg_info(writedata) == INFO_FLUSH);
      push_s       = sw_write_s && !info_flush_s;
      blank_rise_s = in_blank_r && !in_blank_prev_r;
   end

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .push_data (writedata),
      .pop       (pop_s),
      .pop_data  (fifo_data_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .level     (fifo_level)
   );

   // Registered blanking flag and its previous value for rise detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_blank_r      <= 1'b0;
         in_blank_prev_r <= 1'b0;
      end else begin
         in_blank_r      <= (vcount >= VBLANK_LINE);
         in_blank_prev_r <= in_blank_r;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic. A blank rise seen outside IDLE is ignored.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (blank_rise_s) begin
               state_next_s = FLUSH;
            end else begin
               state_next_s = IDLE;
            end
         end
         FLUSH: begin
            state_next_s = DRAIN;
         end
         DRAIN: begin
            if (!fifo_empty_s && in_blank_r) begin
               state_next_s = DRAIN;
            end else begin
               state_next_s = IDLE;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // FSM output logic. The word chosen here is registered onto cmd_out, so the
   // flush word appears the cycle after the rise and the first entry the cycle
   // after that (draining already starts while the FSM sits in FLUSH).
   always_comb begin
      pop_s      = 1'b0;
      toggle_s   = 1'b0;
      cmd_next_s = NOP_WORD;
      case (state_r)
         IDLE: begin
            if (blank_rise_s) begin
               toggle_s   = 1'b1;
               cmd_next_s = make_flush_word(~front_buffer_r);
            end else begin
               toggle_s   = 1'b0;
               cmd_next_s = NOP_WORD;
            end
         end
         FLUSH, DRAIN: begin
            // front_buffer_r already holds the newly activated buffer here.
            if (!fifo_empty_s && in_blank_r) begin
               pop_s      = 1'b1;
               cmd_next_s = with_buffer(fifo_data_s, front_buffer_r);
            end else begin
               pop_s      = 1'b0;
               cmd_next_s = NOP_WORD;
            end
         end
         default: begin
            pop_s      = 1'b0;
            toggle_s   = 1'b0;
            cmd_next_s = NOP_WORD;
         end
      endcase
   end

   // Output word, front buffer and sticky error flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_out_r      <= NOP_WORD;
         front_buffer_r <= 1'b0;
         overflow_r     <= 1'b0;
         rejected_r     <= 1'b0;
      end else begin
         cmd_out_r      <= cmd_next_s;
         front_buffer_r <= front_buffer_r ^ toggle_s;
         overflow_r     <= overflow_r | (push_s && fifo_full_s);
         rejected_r     <= rejected_r | (sw_write_s && info_flush_s);
      end
   end

   always_comb begin
      cmd_out      = cmd_out_r;
      front_buffer = front_buffer_r;
      overflow     = overflow_r;
      rejected     = rejected_r;
   end

endmodule

// File: tb/tb_sprite_cmd_dispatcher.sv
// Self-checking bench for sprite_cmd_dispatcher: a queue-based reference model
// is compared against every output on every falling clock edge, and directed
// scenarios add hand-computed literal expectations.
module tb_sprite_cmd_dispatcher;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        chipselect = 1'b0;
   logic        write = 1'b0;
   logic [31:0] writedata = 32'h0;
   logic [9:0]  vcount = 10'd0;
   logic [31:0] cmd_out;
   logic        front_buffer;
   logic [6:0]  fifo_level;
   logic        overflow;
   logic        rejected;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   sprite_cmd_dispatcher dut (
      .clk          (clk),
      .reset        (reset),
      .chipselect   (chipselect),
      .write        (write),
      .writedata    (writedata),
      .vcount       (vcount),
      .cmd_out      (cmd_out),
      .front_buffer (front_buffer),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .rejected     (rejected)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Queue of pending words; a "burst" starts with a flush word on the first
   // cycle the (one-cycle delayed) blank indication rises and continues while
   // words remain and blanking is still indicated.
   logic [31:0] mq[$];
   bit          m_fb = 0, m_ovf = 0, m_rej = 0, m_burst = 0;
   bit          m_blank = 0, m_blank_old = 0;
   logic [31:0] m_cmd = 32'h0;

   function automatic logic [31:0] flush_of(input bit b);
      return {6'h00, 5'h00, 4'hF, 3'h0, b, 13'h0};
   endfunction

   task automatic model_step();
      int          sz;
      logic [31:0] w;
      if (!reset) begin
         mq.delete();
         m_fb = 0; m_ovf = 0; m_rej = 0; m_burst = 0;
         m_blank = 0; m_blank_old = 0; m_cmd = 32'h0;
         return;
      end
      sz    = mq.size();
      m_cmd = 32'h0;
      if (!m_burst && m_blank && !m_blank_old) begin
         m_fb    = !m_fb;
         m_cmd   = flush_of(m_fb);
         m_burst = 1;
      end else if (m_burst && sz > 0 && m_blank) begin
         w     = mq.pop_front();
         w[13] = m_fb;
         m_cmd = w;
      end else begin
         m_burst = 0;
      end
      if (chipselect && write) begin
         if (writedata[20:17] == 4'hF) m_rej = 1;
         else if (sz >= 64)            m_ovf = 1;
         else                          mq.push_back(writedata);
      end
      m_blank_old = m_blank;
      m_blank     = (vcount >= 10'd480);
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge reset);
         model_step();
      end
   end

   // Compare every output against the model away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            check("cmp_cmd_out", cmd_out, m_cmd);
            check("cmp_front_buffer", {31'd0, front_buffer}, {31'd0, m_fb});
            check("cmp_fifo_level", {25'd0, fifo_level}, mq.size());
            check("cmp_overflow", {31'd0, overflow}, {31'd0, m_ovf});
            check("cmp_rejected", {31'd0, rejected}, {31'd0, m_rej});
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [31:0] w);
      chipselect = 1'b1; write = 1'b1; writedata = w;
      tick(1);
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 reset = 1'b0;
      vcount = 10'd0; chipselect = 1'b0; write = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(3);
   endtask

   // Returns at the falling edge where the flush word is visible.
   task automatic wait_flush(output int n);
      bit found;
      found = 0;
      n = 0;
      while (!found && n < 200) begin
         @(negedge clk);
         n++;
         if (cmd_out[20:17] == 4'hF) found = 1;
      end
      check("wait_flush", {31'd0, found}, 32'd1);
   endtask

   initial begin
      int n;
      int cnt;
      #2 reset = 1'b0;
      cmp_en = 1'b1;
      tick(2);
      check("rst_cmd_out", cmd_out, 32'h0000_0000);
      check("rst_front_buffer", {31'd0, front_buffer}, 32'd0);
      check("rst_fifo_level", {25'd0, fifo_level}, 32'd0);
      check("rst_flags", {30'd0, overflow, rejected}, 32'd0);
      reset = 1'b1;
      tick(3);

      // Single message: held until blanking, bit 13 forced to new front buffer.
      vcount = 10'd100;
      tick(2);
      write_word(32'h3802_0005);
      tick(10);
      vcount = 10'd480;
      wait_flush(n);
      // vcount set just after an edge: in_blank after 1 edge, flush after 2,
      // i.e. on the third falling edge counted.
      check("blank_to_flush_latency", n, 32'd3);
      check("flush_word_1", cmd_out, 32'h001E_2000);
      check("front_buffer_1", {31'd0, front_buffer}, 32'd1);
      @(negedge clk);
      check("drained_word_1", cmd_out, 32'h3802_2005);
      @(negedge clk);
      check("nop_after_drain", cmd_out, 32'h0);
      check("level_after_drain", {25'd0, fifo_level}, 32'd0);
      vcount = 10'd0;
      tick(6);

      // Overflow: 65 pushes, 64 kept and released in order.
      for (int i = 0; i < 65; i++) write_word(32'h0400_0000 | i);
      check("ovf_level", {25'd0, fifo_level}, 32'd64);
      check("ovf_flag", {31'd0, overflow}, 32'd1);
      vcount = 10'd500;
      wait_flush(n);
      check("ovf_flush_word", cmd_out, 32'h001E_0000);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         check("ovf_order", cmd_out, 32'h0400_0000 | i);
      end
      @(negedge clk);
      check("ovf_65th_absent", cmd_out, 32'h0);
      check("ovf_level_empty", {25'd0, fifo_level}, 32'd0);
      vcount = 10'd0;
      tick(6);

      // Partial drain: blanking ends mid-burst, leftovers wait a frame.
      do_reset();
      for (int i = 0; i < 10; i++) write_word(32'h0C00_0000 | i);
      vcount = 10'd480;
      wait_flush(n);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (cmd_out != 32'h0) cnt++;
      end
      vcount = 10'd0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (cmd_out != 32'h0) cnt++;
      end
      check("partial_released", cnt, 32'd5);
      check("partial_level", {25'd0, fifo_level}, 32'd5);
      tick(4);
      vcount = 10'd481;
      wait_flush(n);
      check("partial_flush_buf0", cmd_out, 32'h001E_0000);
      for (int i = 5; i < 10; i++) begin
         @(negedge clk);
         check("partial_rest", cmd_out, 32'h0C00_0000 | i);
      end
      vcount = 10'd0;
      tick(6);

      // Software word with info = F is discarded.
      write_word(32'h1000_0001);
      write_word(32'h1000_0002);
      write_word(32'h001E_0000);
      check("reject_flag", {31'd0, rejected}, 32'd1);
      check("reject_level", {25'd0, fifo_level}, 32'd2);
      tick(3);

      // Push and pop in the same cycle during a burst.
      do_reset();
      for (int i = 0; i < 3; i++) write_word(32'h1400_0000 | i);
      vcount = 10'd600;
      wait_flush(n);
      chipselect = 1'b1; write = 1'b1; writedata = 32'h0800_1234;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0;
      check("pushpop_level", {25'd0, fifo_level}, 32'd3);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("pushpop_new_last", cmd_out, 32'h0800_3234);
      vcount = 10'd0;
      tick(6);

      // Asynchronous reset during the third drain cycle.
      do_reset();
      for (int i = 0; i < 8; i++) write_word(32'h1800_0000 | i);
      vcount = 10'd480;
      wait_flush(n);
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("async_rst_cmd_out", cmd_out, 32'h0);
      check("async_rst_level", {25'd0, fifo_level}, 32'd0);
      check("async_rst_front_buffer", {31'd0, front_buffer}, 32'd0);
      vcount = 10'd0;
      tick(2);
      reset = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cmd_out != 32'h0) cnt++;
      end
      check("after_rst_no_words", cnt, 32'd0);

      // Randomized frames with random writes, boundary vcount values included.
      for (int f = 0; f < 8; f++) begin
         int alen;
         int blen;
         alen = $urandom_range(20, 60);
         blen = $urandom_range(10, 60);
         for (int c = 0; c < alen + blen; c++) begin
            if (c < alen) vcount = ($urandom_range(0, 3) == 0) ? 10'd479 : 10'($urandom_range(0, 479));
            else          vcount = ($urandom_range(0, 3) == 0) ? 10'd480 : 10'($urandom_range(480, 1023));
            chipselect = ($urandom_range(0, 3) != 0);
            write      = ($urandom_range(0, 2) != 0);
            writedata  = $urandom;
            if ($urandom_range(0, 7) == 0) writedata[20:17] = 4'hF;
            tick(1);
         end
      end
      chipselect = 1'b0; write = 1'b0; vcount = 10'd0;
      tick(5);
      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
